// File: rtl/vga_sync_gen.sv
// Raster timing generator: walks (h,v) across the full VGA frame on each pixel tick
// and emits registered sync, active-video, coordinate and line/frame strobes.
module vga_sync_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int bit_width = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 video_on,
  output logic [bit_width-1:0] pixel_x,
  output logic [bit_width-1:0] pixel_y,
  output logic                 line_start,
  output logic                 frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [bit_width-1:0] H_LAST       = bit_width'(H_TOTAL - 1);
  localparam logic [bit_width-1:0] H_FP_START   = bit_width'(H_ACTIVE);
  localparam logic [bit_width-1:0] H_SYNC_START = bit_width'(H_ACTIVE + H_FP);
  localparam logic [bit_width-1:0] H_BP_START   = bit_width'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [bit_width-1:0] V_LAST       = bit_width'(V_TOTAL - 1);
  localparam logic [bit_width-1:0] V_FP_START   = bit_width'(V_ACTIVE);
  localparam logic [bit_width-1:0] V_SYNC_START = bit_width'(V_ACTIVE + V_FP);
  localparam logic [bit_width-1:0] V_BP_START   = bit_width'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [1:0] PH_ACTIVE = 2'd0;
  localparam logic [1:0] PH_FP     = 2'd1;
  localparam logic [1:0] PH_SYNC   = 2'd2;
  localparam logic [1:0] PH_BP     = 2'd3;

  // clk_en is a qualifier, not a handshake: every enabled edge advances one pixel,
  // there is no backpressure, and outputs are valid on every clk.

  logic [bit_width-1:0] h, v;
  logic [bit_width-1:0] h_nxt, v_nxt;
  logic                 h_wrap;
  logic [1:0]           h_state, v_state;
  logic [1:0]           h_state_nxt, v_state_nxt;

  // Phase entry is detected on the coordinate just being entered; the order lets
  // a zero-width phase hand over to the following one at the same position.
  function automatic logic [1:0] phase_next(
    input logic [1:0]           cur,
    input logic [bit_width-1:0] pos,
    input logic [bit_width-1:0] fp_start,
    input logic [bit_width-1:0] sync_start,
    input logic [bit_width-1:0] bp_start
  );
    logic [1:0] nxt;
    nxt = cur;
    if (pos == '0)              nxt = PH_ACTIVE;
    else if (pos == bp_start)   nxt = PH_BP;
    else if (pos == sync_start) nxt = PH_SYNC;
    else if (pos == fp_start)   nxt = PH_FP;
    return nxt;
  endfunction

  always_comb begin
    h_wrap = (h == H_LAST);
    h_nxt  = h_wrap ? '0 : h + 1'b1;
    v_nxt  = v;
    if (h_wrap) begin
      v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
    end
  end

  always_comb begin
    h_state_nxt = phase_next(h_state, h_nxt, H_FP_START, H_SYNC_START, H_BP_START);
    v_state_nxt = v_state;
    if (h_wrap) begin
      v_state_nxt = phase_next(v_state, v_nxt, V_FP_START, V_SYNC_START, V_BP_START);
    end
  end

  // Reset parks the counters on the last pixel so the first tick lands on (0,0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h       <= H_LAST;
      v       <= V_LAST;
      h_state <= PH_BP;
      v_state <= PH_BP;
    end else if (clk_en) begin
      h       <= h_nxt;
      v       <= v_nxt;
      h_state <= h_state_nxt;
      v_state <= v_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      video_on    <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (clk_en) begin
        pixel_x     <= h_nxt;
        pixel_y     <= v_nxt;
        video_on    <= (h_state_nxt == PH_ACTIVE) && (v_state_nxt == PH_ACTIVE);
        hsync       <= (h_state_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        vsync       <= (v_state_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        line_start  <= h_wrap;
        frame_start <= h_wrap && (v_nxt == '0);
      end
    end
  end

endmodule
